// File: rtl/reductor_arbiter.sv
// Two-input packet-atomic round-robin arbiter with per-input FIFOs feeding one flit channel.
// Optional REDUCTOR_ARB_STATS_EN adds saturating per-input grant counters.
module reductor_arbiter #(
  parameter int unsigned FLIT_SIZE = 144,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLIT_SIZE-1:0] in0_i,
  input  logic [FLIT_SIZE-1:0] in1_i,
  input  logic                 in0_valid_i,
  input  logic                 in1_valid_i,
  output logic                 in0_avail_o,
  output logic                 in1_avail_o,
  output logic [FLIT_SIZE-1:0] out_o,
  output logic                 out_valid_o,
  input  logic                 out_avail_i,
  output logic                 proto_err_o
`ifdef REDUCTOR_ARB_STATS_EN
  ,
  output logic [15:0]          grant_cnt0_o,
  output logic [15:0]          grant_cnt1_o
`endif
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_e;

  // FIFO storage and bookkeeping, indexed by input number
  logic [FLIT_SIZE-1:0] mem_q    [2][BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q [2];
  logic [PTR_W-1:0]     wr_ptr_d [2];
  logic [PTR_W-1:0]     rd_ptr_q [2];
  logic [PTR_W-1:0]     rd_ptr_d [2];
  logic [CNT_W-1:0]     cnt_q    [2];
  logic [CNT_W-1:0]     cnt_d    [2];
  logic [1:0]           avail_q;
  logic [1:0]           avail_d;

  logic [FLIT_SIZE-1:0] in_flit_c [2];
  logic [FLIT_SIZE-1:0] front_c   [2];
  logic [1:0]           in_valid_c;
  logic [1:0]           push_c;
  logic [1:0]           pop_c;
  logic [1:0]           nempty_c;

  state_e state_q, state_d;
  logic   rr_q, rr_d;
  logic   perr_q, perr_d;

  logic                 grant_c;
  logic                 launch_c;
  logic [FLIT_SIZE-1:0] launch_flit_c;
  logic [1:0]           launch_type_c;

  logic [FLIT_SIZE-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  assign in_flit_c[0] = in0_i;
  assign in_flit_c[1] = in1_i;
  assign in_valid_c   = {in1_valid_i, in0_valid_i};

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      front_c[n]  = mem_q[n][rd_ptr_q[n]];
      nempty_c[n] = (cnt_q[n] != '0);
    end
  end

  // FIFO next-state; avail looks ahead so an accepted flit always has a free slot
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      push_c[n]   = in_valid_c[n] & avail_q[n];
      pop_c[n]    = launch_c & (grant_c == 1'(n));
      wr_ptr_d[n] = wr_ptr_q[n] + PTR_W'(push_c[n]);
      rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(pop_c[n]);
      cnt_d[n]    = cnt_q[n] + CNT_W'(push_c[n]) - CNT_W'(pop_c[n]);
      avail_d[n]  = (cnt_d[n] <= CNT_W'(BUF_DEPTH - 2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        cnt_q[n]    <= '0;
      end
      avail_q <= 2'b11;
    end else begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        cnt_q[n]    <= cnt_d[n];
      end
      avail_q <= avail_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push_c[n]) begin
        mem_q[n][wr_ptr_q[n]] <= in_flit_c[n];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      perr_q  <= perr_d;
    end
  end

  assign launch_flit_c = front_c[grant_c];
  assign launch_type_c = launch_flit_c[FLIT_SIZE-1 -: 2];

  // FSM next state: lock on head, release on tail, flip rr after every packet
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    perr_d  = perr_q;
    unique case (state_q)
      S_IDLE: begin
        if (launch_c) begin
          if (launch_type_c == FT_HEAD) begin
            state_d = grant_c ? S_LOCK1 : S_LOCK0;
          end else begin
            rr_d = ~grant_c;
            if (launch_type_c != FT_SINGLE) begin
              perr_d = 1'b1;
            end
          end
        end
      end
      S_LOCK0, S_LOCK1: begin
        if (launch_c && (launch_type_c == FT_TAIL)) begin
          state_d = S_IDLE;
          rr_d    = ~grant_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: grant selection and launch enable
  always_comb begin
    grant_c  = rr_q;
    launch_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        grant_c  = nempty_c[rr_q] ? rr_q : ~rr_q;
        launch_c = out_avail_i & (|nempty_c);
      end
      S_LOCK0: begin
        grant_c  = 1'b0;
        launch_c = out_avail_i & nempty_c[0];
      end
      S_LOCK1: begin
        grant_c  = 1'b1;
        launch_c = out_avail_i & nempty_c[1];
      end
      default: begin
        grant_c  = rr_q;
        launch_c = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = launch_c;
    out_d       = launch_c ? launch_flit_c : out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign in0_avail_o = avail_q[0];
  assign in1_avail_o = avail_q[1];
  assign proto_err_o = perr_q;

`ifdef REDUCTOR_ARB_STATS_EN
  logic [15:0] grant_cnt_q [2];
  logic [15:0] grant_cnt_d [2];

  // Saturating per-input launch counters
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      grant_cnt_d[n] = grant_cnt_q[n];
      if (pop_c[n] && (grant_cnt_q[n] != 16'hFFFF)) begin
        grant_cnt_d[n] = grant_cnt_q[n] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q[0] <= '0;
      grant_cnt_q[1] <= '0;
    end else begin
      grant_cnt_q[0] <= grant_cnt_d[0];
      grant_cnt_q[1] <= grant_cnt_d[1];
    end
  end

  assign grant_cnt0_o = grant_cnt_q[0];
  assign grant_cnt1_o = grant_cnt_q[1];
`endif

endmodule

// File: doc/reductor_arbiter.md
# reductor_arbiter

Two-input, packet-atomic round-robin arbiter that shares one downstream flit channel between two upstream flit streams. It sits in front of a reduction/merge output port, buffers each input in a small FIFO, and grants whole packets (head through tail) alternately. All handshakes use the valid/avail flow control used across the router datapath.

## Interface
- FLIT_SIZE, 144: flit width in bits; bits [FLIT_SIZE-1:FLIT_SIZE-2] are the flit type: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head+tail).
- BUF_DEPTH, 4: entries per input FIFO; power of two, at least 2.

- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in0, in1  input  FLIT_SIZE  upstream flits.
- in0_valid, in1_valid  input  1  flit present on inN this cycle.
- in0_avail, in1_avail  output  1  registered; upstream may drive valid this cycle.
- out  output  FLIT_SIZE  registered output flit.
- out_valid  output  1  registered; one-cycle pulse per flit.
- out_avail  input  1  downstream can accept a flit launched this cycle.
- proto_err  output  1  sticky; non-head/non-single flit found at a FIFO front while IDLE.

## Operation
- Input accept: inN flit is written to FIFO N when inN_valid && inN_avail. Upstream must not drive valid while avail is low; such a flit is ignored.
- inN_avail is registered high when FIFO N will hold at most BUF_DEPTH-2 entries after the current edge. A flit sent while avail is high therefore always fits. Simultaneous push and pop counts as net zero.
- Launch: when out_avail is high and the granted FIFO is non-empty, pop its front into `out` and set out_valid for one cycle. Otherwise out_valid = 0 and `out` holds its value.
- FSM states:
  - IDLE: candidates are non-empty FIFOs. The rr pointer picks the candidate, with the other input as fallback. Launch happens in the same cycle if out_avail is high.
    - Launched flit is single: stay IDLE, rr = other input.
    - Launched flit is head: go to LOCKn.
  - LOCK0 / LOCK1: only FIFO n may launch.
    - Launch tail: go to IDLE, rr = other input.
    - Launch body or head: stay.
    - Empty FIFO n stalls without releasing the lock.
- Protocol error: a body or tail flit at the front in IDLE is launched as if single, sets proto_err, and rr flips.
- Both inputs may push while one pops, all in the same cycle.

## Timing
- Reset (rst low, asynchronous):
  - out_valid = 0, out = 0, in0_avail = in1_avail = 1, proto_err = 0.
  - FIFOs empty, state IDLE, rr = 0.
  - Reset mid-packet discards buffered flits and the lock.
- Latency: flit accepted at edge N appears with out_valid high in the cycle after edge N+1, if granted and out_avail is high at N+1. Minimum 2 cycles.
- Throughput: one flit per cycle while out_avail is high and the granted FIFO is non-empty.
- FIFO pointers are log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH. The count is log2(BUF_DEPTH)+1 bits.
- Full FIFO: avail low. Empty FIFO: never popped.

## Configuration
- REDUCTOR_ARB_STATS_EN defined: adds outputs grant_cnt0 and grant_cnt1 (16 bits each).
  - Each counts flits launched from its input.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Single flits, both inputs valid every cycle, out_avail = 1: output alternates in0, in1, in0, …; first out_valid 2 cycles after the first accept; steady rate 1 flit/cycle.
- in0 sends a 4-flit packet (head, body, body, tail) while in1 sends singles: the 4 in0 flits appear contiguous, then one in1 flit; rr ends at 0.
- out_avail held low for 10 cycles with both inputs streaming: in0_avail and in1_avail fall after BUF_DEPTH-1 accepts; no flit is lost or duplicated after release, in order per input.
- in1 head launched, then in1 FIFO empty for 5 cycles while in0 holds singles: no in0 flit output until the in1 tail passes.
- A tail flit arrives at in0 with no prior head: it is forwarded, proto_err = 1 and stays 1.
- rst asserted mid-packet: all outputs return to reset values asynchronously; after release, a single on in1 is output normally 2 cycles later. With REDUCTOR_ARB_STATS_EN, the counters clear and then count correctly.
